// File: rtl/lp_down_collector_pkg.sv
// Shared definitions for the LP down-lane collector.
//   row_state_e : row-tracking FSM encoding (IDLE / ROW)
//   ptr_width() : lane-pointer width for a given lane count
package lp_down_collector_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ROW  = 1'b1
   } row_state_e;

   localparam int unsigned DEFAULT_LANES = 4;

   // Pointer width for a given lane count, never narrower than one bit.
   function automatic int unsigned ptr_width(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   localparam int unsigned DEFAULT_PTR_W = ptr_width(DEFAULT_LANES);

endpackage

// File: rtl/lp_lane_holder.sv
// One-entry AXI-Stream holding register for a single down lane.
//   clk, rst                          : clock, async active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast/s_tuser : lane input
//   drain                             : the held beat leaves this cycle
//   hold_valid/hold_data/hold_last/hold_user  : held beat
module lp_lane_holder
   import lp_down_collector_pkg::*;
#(
   parameter int unsigned D_WIDTH    = 16,
   parameter int unsigned USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [D_WIDTH-1:0]    s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic [USER_WIDTH-1:0] s_tuser,
   input  logic                  drain,
   output logic                  hold_valid,
   output logic [D_WIDTH-1:0]    hold_data,
   output logic                  hold_last,
   output logic [USER_WIDTH-1:0] hold_user
);

   logic                  valid_q, valid_d;
   logic [D_WIDTH-1:0]    data_q,  data_d;
   logic                  last_q,  last_d;
   logic [USER_WIDTH-1:0] user_q,  user_d;
   logic                  load;

   // Ready while empty or while the held beat leaves, so refills need no bubble.
   always_comb begin
      s_tready = !valid_q || drain;
      load     = s_tvalid && s_tready;
      valid_d  = valid_q;
      data_d   = data_q;
      last_d   = last_q;
      user_d   = user_q;
      if (drain) valid_d = 1'b0;
      if (load) begin
         valid_d = 1'b1;
         data_d  = s_tdata;
         last_d  = s_tlast;
         user_d  = s_tuser;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
   end

   // Payload is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      last_q <= last_d;
      user_q <= user_d;
   end

   assign hold_valid = valid_q;
   assign hold_data  = data_q;
   assign hold_last  = last_q;
   assign hold_user  = user_q;

endmodule

// File: rtl/lp_down_collector.sv
// Merges PE_NUMBER_I down lanes into one stream, one beat per lane in
// lane order 0..I-1 per row, tagging each beat with its lane in tid.
//   clk, rst          : clock, async active-high reset
//   s_axis_down_*     : per-lane inputs, lane i on slice i
//   m_axis_*          : merged output; tdest is the constant OUTPUT_DEST
//   err_unalligned_data : sticky, a row closed with mixed tlast bits
//   err_user_flag       : sticky, a beat left with non-zero tuser
module lp_down_collector
   import lp_down_collector_pkg::*;
#(
   parameter int unsigned PE_NUMBER_I = 4,
   parameter int unsigned U_D_WIDTH   = 16,
   parameter int unsigned ID_WIDTH    = 8,
   parameter int unsigned DEST_WIDTH  = 8,
   parameter int unsigned USER_WIDTH  = 1,
   parameter int unsigned OUTPUT_DEST = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [PE_NUMBER_I*U_D_WIDTH-1:0]  s_axis_down_tdata,
   input  logic [PE_NUMBER_I-1:0]            s_axis_down_tvalid,
   output logic [PE_NUMBER_I-1:0]            s_axis_down_tready,
   input  logic [PE_NUMBER_I-1:0]            s_axis_down_tlast,
   input  logic [PE_NUMBER_I*USER_WIDTH-1:0] s_axis_down_tuser,
   output logic [U_D_WIDTH-1:0]              m_axis_tdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic [ID_WIDTH-1:0]               m_axis_tid,
   output logic [DEST_WIDTH-1:0]             m_axis_tdest,
   output logic [USER_WIDTH-1:0]             m_axis_tuser,
   output logic                              err_unalligned_data,
   output logic                              err_user_flag
);

   localparam int unsigned      PTR_W     = ptr_width(PE_NUMBER_I);
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(PE_NUMBER_I - 1);

   logic [PE_NUMBER_I-1:0] hold_valid;
   logic [PE_NUMBER_I-1:0] hold_last;
   logic [PE_NUMBER_I-1:0] drain;
   logic [U_D_WIDTH-1:0]   hold_data [PE_NUMBER_I];
   logic [USER_WIDTH-1:0]  hold_user [PE_NUMBER_I];

   row_state_e       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             row_or_q, row_or_d;
   logic             row_and_q, row_and_d;
   logic             err_unal_q, err_unal_d;
   logic             err_user_q, err_user_d;
   logic             hs;
   logic             cur_last;

   for (genvar gi = 0; gi < PE_NUMBER_I; gi++) begin : g_lane
      lp_lane_holder #(
         .D_WIDTH    (U_D_WIDTH),
         .USER_WIDTH (USER_WIDTH)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .s_tdata    (s_axis_down_tdata[gi*U_D_WIDTH +: U_D_WIDTH]),
         .s_tvalid   (s_axis_down_tvalid[gi]),
         .s_tready   (s_axis_down_tready[gi]),
         .s_tlast    (s_axis_down_tlast[gi]),
         .s_tuser    (s_axis_down_tuser[gi*USER_WIDTH +: USER_WIDTH]),
         .drain      (drain[gi]),
         .hold_valid (hold_valid[gi]),
         .hold_data  (hold_data[gi]),
         .hold_last  (hold_last[gi]),
         .hold_user  (hold_user[gi])
      );
   end

   // Output is driven straight from the selected holding register.
   assign m_axis_tvalid       = hold_valid[ptr_q];
   assign m_axis_tdata        = hold_data[ptr_q];
   assign m_axis_tuser        = hold_user[ptr_q];
   assign m_axis_tlast        = (ptr_q == LAST_LANE) && hold_last[PE_NUMBER_I-1];
   assign m_axis_tid          = ID_WIDTH'(ptr_q);
   assign m_axis_tdest        = DEST_WIDTH'(OUTPUT_DEST);
   assign err_unalligned_data = err_unal_q;
   assign err_user_flag       = err_user_q;
   assign hs                  = m_axis_tvalid && m_axis_tready;
   assign cur_last            = hold_last[ptr_q];

   always_comb begin
      for (int unsigned i = 0; i < PE_NUMBER_I; i++) begin
         drain[i] = hs && (ptr_q == PTR_W'(i));
      end
   end

   // Row pointer, row FSM and tlast-alignment / tuser error tracking.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      row_or_d   = row_or_q;
      row_and_d  = row_and_q;
      err_unal_d = err_unal_q;
      err_user_d = err_user_q;
      if (hs) begin
         if (m_axis_tuser != '0) err_user_d = 1'b1;
         if (ptr_q == LAST_LANE) begin
            // Row closes: compare including this final beat's last bit.
            if ((row_or_q | cur_last) != (row_and_q & cur_last)) err_unal_d = 1'b1;
            ptr_d     = '0;
            state_d   = ST_IDLE;
            row_or_d  = 1'b0;
            row_and_d = 1'b1;
         end else begin
            ptr_d     = ptr_q + PTR_W'(1);
            row_or_d  = row_or_q | cur_last;
            row_and_d = row_and_q & cur_last;
            if (state_q == ST_IDLE) state_d = ST_ROW;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         row_or_q   <= 1'b0;
         row_and_q  <= 1'b1;
         err_unal_q <= 1'b0;
         err_user_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         row_or_q   <= row_or_d;
         row_and_q  <= row_and_d;
         err_unal_q <= err_unal_d;
         err_user_q <= err_user_d;
      end
   end

endmodule

// File: tb/tb_lp_down_collector.sv
// Randomised bench for lp_down_collector. The reference model keeps the
// beats each lane accepted and expects them out row-major: row k is the
// k-th beat of lane 0, 1, 2, 3.
module tb_lp_down_collector;

   localparam int unsigned LANES = 4;
   localparam int unsigned DW    = 16;
   localparam logic [7:0]  DEST  = 8'h5A;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } in_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [7:0]    lane;
      logic          last;
      logic          user;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [LANES*DW-1:0]   s_tdata;
   logic [LANES-1:0]      s_valid;
   logic [LANES-1:0]      s_ready;
   logic [LANES-1:0]      s_last;
   logic [LANES-1:0]      s_user;
   logic [DW-1:0]         m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;
   logic [7:0]            m_tid;
   logic [7:0]            m_dest;
   logic [0:0]            m_user;
   logic                  err_unal;
   logic                  err_user;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned gap_pct  = 0;

   in_t   pend [LANES][$];
   in_t   acc  [LANES][$];
   beat_t obs  [$];
   beat_t exp_q[$];
   logic  exp_unal;
   logic  exp_user;

   always #5 clk = ~clk;

   lp_down_collector #(
      .PE_NUMBER_I (LANES), .U_D_WIDTH (DW), .ID_WIDTH (8),
      .DEST_WIDTH (8), .USER_WIDTH (1), .OUTPUT_DEST (32'h5A)
   ) dut (
      .clk (clk), .rst (rst),
      .s_axis_down_tdata (s_tdata), .s_axis_down_tvalid (s_valid),
      .s_axis_down_tready (s_ready), .s_axis_down_tlast (s_last),
      .s_axis_down_tuser (s_user),
      .m_axis_tdata (m_data), .m_axis_tvalid (m_valid), .m_axis_tready (m_ready),
      .m_axis_tlast (m_last), .m_axis_tid (m_tid), .m_axis_tdest (m_dest),
      .m_axis_tuser (m_user),
      .err_unalligned_data (err_unal), .err_user_flag (err_user)
   );

   // Reference: interleave accepted lane beats row by row; errors from rows.
   task automatic build_exp();
      bit done = 1'b0;
      int cnt;
      exp_q.delete();
      exp_unal = 1'b0;
      exp_user = 1'b0;
      for (int k = 0; !done; k++) begin
         cnt = 0;
         for (int l = 0; l < LANES; l++) begin
            if (!done) begin
               if (acc[l].size() <= k) done = 1'b1;
               else begin
                  exp_q.push_back(beat_t'({acc[l][k].data, 8'(l), (l == LANES-1) && acc[l][k].last, acc[l][k].user}));
                  cnt += int'(acc[l][k].last);
                  if (acc[l][k].user) exp_user = 1'b1;
                  if (l == LANES-1 && cnt != 0 && cnt != LANES) exp_unal = 1'b1;
               end
            end
         end
      end
   endtask

   // One clock: drive lanes from pend, account accepts/outputs at negedge.
   task automatic tick(input int mode);
      logic [LANES-1:0] took;
      for (int i = 0; i < LANES; i++) begin
         if (!s_valid[i] && pend[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) s_valid[i] = 1'b1;
         if (s_valid[i]) begin
            s_tdata[i*DW +: DW] = pend[i][0].data;
            s_last[i]           = pend[i][0].last;
            s_user[i]           = pend[i][0].user;
         end
      end
      m_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      took = '0;
      for (int i = 0; i < LANES; i++) begin
         if (s_valid[i] && s_ready[i]) begin
            took[i] = 1'b1;
            acc[i].push_back(pend[i].pop_front());
         end
      end
      if (m_valid && m_ready) obs.push_back(beat_t'({m_data, m_tid, m_last, m_user[0]}));
      @(posedge clk);
      #1;
      s_valid = s_valid & ~took;
   endtask

   task automatic drain(input int mode, input int max_cyc);
      int n = 0;
      while (!(pend[0].size() == 0 && pend[1].size() == 0 && pend[2].size() == 0 &&
               pend[3].size() == 0 && !m_valid && s_ready == 4'hF) && n < max_cyc) begin
         tick(mode);
         n++;
      end
      n_checks++;
      if (n >= max_cyc) begin
         n_fail++;
         $display("FAIL drain_timeout: still busy after %0d cycles", n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_valid = '0;
      m_ready = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         pend[l].delete();
         acc[l].delete();
      end
      obs.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push_row(input logic [DW-1:0] base, input logic [3:0] lasts, input logic [3:0] users);
      for (int l = 0; l < LANES; l++) pend[l].push_back(in_t'({DW'(base + DW'(l)), lasts[l], users[l]}));
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = '0; s_tdata = '0; s_last = '0; s_user = '0; m_ready = 1'b0;
      #1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_valid); end
      n_checks++; if (s_ready !== 4'hF) begin n_fail++; $display("FAIL reset_tready: got %b want 1111", s_ready); end
      n_checks++; if ({err_unal, err_user} !== 2'b00) begin n_fail++; $display("FAIL reset_errors: got %b want 00", {err_unal, err_user}); end
      n_checks++; if (m_dest !== DEST) begin n_fail++; $display("FAIL reset_tdest: got %h want %h", m_dest, DEST); end
      do_reset();
   endtask

   task automatic test_in_order();
      do_reset();
      gap_pct = 0;
      for (int l = 0; l < LANES; l++) pend[l].push_back(in_t'({DW'(16'h0011 * (l + 1)), 1'b0, 1'b0}));
      drain(1, 50);
      build_exp();
      n_checks++; if (obs.size() != 4) begin n_fail++; $display("FAIL in_order_count: got %0d want 4", obs.size()); end
      for (int k = 0; k < obs.size() && k < 4; k++) begin
         n_checks++;
         if (obs[k] !== beat_t'({DW'(16'h0011 * (k + 1)), 8'(k), 1'b0, 1'b0}) || obs[k] !== exp_q[k]) begin
            n_fail++; $display("FAIL in_order_beat%0d: got %h want %h", k, obs[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_out_of_order();
      do_reset();
      gap_pct = 0;
      pend[2].push_back(in_t'({16'hABCD, 1'b0, 1'b0}));
      for (int k = 0; k < 4; k++) begin
         tick(1);
         n_checks++;
         if (m_valid !== 1'b0 || s_ready[2] !== 1'b0) begin
            n_fail++; $display("FAIL ooo_wait%0d: tvalid=%b tready2=%b want 0,0", k, m_valid, s_ready[2]);
         end
      end
      pend[0].push_back(in_t'({16'h1111, 1'b0, 1'b0}));
      pend[1].push_back(in_t'({16'h2222, 1'b0, 1'b0}));
      tick(1);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h1111 || m_tid !== 8'd0) begin
         n_fail++; $display("FAIL ooo_latency: tvalid=%b data=%h tid=%0d want 1,1111,0", m_valid, m_data, m_tid);
      end
      drain(1, 50);
      build_exp();
      n_checks++; if (obs.size() != 3 || exp_q.size() != 3) begin n_fail++; $display("FAIL ooo_count: got %0d want 3", obs.size()); end
      for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
         n_checks++; if (obs[k] !== exp_q[k]) begin n_fail++; $display("FAIL ooo_beat%0d: got %h want %h", k, obs[k], exp_q[k]); end
      end
      n_checks++; if (obs.size() == 3 && obs[2].data !== 16'hABCD) begin n_fail++; $display("FAIL ooo_lane2: got %h want abcd", obs[2].data); end
   endtask

   task automatic test_backpressure();
      int n = 0;
      do_reset();
      gap_pct = 0;
      push_row(16'($urandom), 4'h0, 4'h0);
      push_row(16'($urandom), 4'h0, 4'h0);
      while (obs.size() < 2 && n < 20) begin tick(1); n++; end
      build_exp();
      for (int k = 0; k < 5; k++) begin
         tick(0);
         n_checks++;
         if (exp_q.size() <= 2 || m_valid !== 1'b1 || m_data !== exp_q[2].data || m_tid !== 8'd2 ||
             m_last !== exp_q[2].last || obs.size() != 2) begin
            n_fail++; $display("FAIL stall%0d: tvalid=%b data=%h tid=%0d beats=%0d want 1,tid 2,2 beats", k, m_valid, m_data, m_tid, obs.size());
         end
      end
      drain(1, 60);
      build_exp();
      n_checks++; if (obs.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", obs.size()); end
      for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
         n_checks++; if (obs[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", k, obs[k], exp_q[k]); end
      end
   endtask

   task automatic test_tlast();
      do_reset();
      gap_pct = 0;
      push_row(16'h1000, 4'hF, 4'h0);
      drain(1, 50);
      n_checks++;
      if (obs.size() != 4 || obs[3].last !== 1'b1 || obs[0].last !== 1'b0 || obs[2].last !== 1'b0) begin
         n_fail++; $display("FAIL tlast_aligned: beats=%0d want tlast only on tid 3", obs.size());
      end
      n_checks++; if (err_unal !== 1'b0) begin n_fail++; $display("FAIL unal_aligned: got %b want 0", err_unal); end
      push_row(16'h2000, 4'b0010, 4'h0);
      drain(1, 50);
      n_checks++; if (err_unal !== 1'b1) begin n_fail++; $display("FAIL unal_mixed: got %b want 1", err_unal); end
      push_row(16'h3000, 4'h0, 4'h0);
      drain(1, 50);
      build_exp();
      n_checks++; if (err_unal !== 1'b1 || exp_unal !== 1'b1) begin n_fail++; $display("FAIL unal_sticky: got %b want 1", err_unal); end
      n_checks++; if (obs.size() != 12 || obs[7].last !== 1'b0) begin n_fail++; $display("FAIL tlast_mixed: beats=%0d", obs.size()); end
   endtask

   task automatic test_user();
      do_reset();
      gap_pct = 0;
      for (int l = 0; l < 3; l++) pend[l].push_back(in_t'({DW'(l), 1'b0, 1'b0}));
      drain(1, 50);
      n_checks++; if (err_user !== 1'b0) begin n_fail++; $display("FAIL user_before: got %b want 0", err_user); end
      pend[3].push_back(in_t'({16'h0003, 1'b0, 1'b1}));
      drain(1, 50);
      n_checks++; if (err_user !== 1'b1) begin n_fail++; $display("FAIL user_after: got %b want 1", err_user); end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      do_reset();
      gap_pct = 0;
      push_row(16'h4000, 4'h0, 4'b0001);
      while (obs.size() < 2 && n < 20) begin tick(1); n++; end
      n_checks++; if (err_user !== 1'b1 || s_ready[3] !== 1'b0) begin n_fail++; $display("FAIL midrst_pre: err_user=%b tready3=%b want 1,0", err_user, s_ready[3]); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || s_ready !== 4'hF || {err_unal, err_user} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_state: tvalid=%b tready=%b err=%b want 0,1111,00", m_valid, s_ready, {err_unal, err_user});
      end
      do_reset();
      push_row(16'h5000, 4'h0, 4'h0);
      drain(1, 50);
      n_checks++;
      if (obs.size() != 4 || obs[0].lane !== 8'd0 || obs[0].data !== 16'h5000) begin
         n_fail++; $display("FAIL midrst_first: beats=%0d want 4 starting tid 0 data 5000", obs.size());
      end
   endtask

   task automatic test_random();
      logic [3:0] lasts;
      do_reset();
      gap_pct = 30;
      for (int r = 0; r < 8; r++) begin
         case ($urandom_range(0, 2))
            0:       lasts = 4'h0;
            1:       lasts = 4'hF;
            default: lasts = 4'($urandom);
         endcase
         for (int l = 0; l < LANES; l++) pend[l].push_back(in_t'({16'($urandom), lasts[l], 1'($urandom_range(0, 15) == 0)}));
      end
      drain(2, 2000);
      build_exp();
      n_checks++; if (obs.size() != 32 || exp_q.size() != 32) begin n_fail++; $display("FAIL rand_count: got %0d want 32", obs.size()); end
      for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
         n_checks++; if (obs[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_beat%0d: got %h want %h", k, obs[k], exp_q[k]); end
      end
      n_checks++; if (err_unal !== exp_unal) begin n_fail++; $display("FAIL rand_unal: got %b want %b", err_unal, exp_unal); end
      n_checks++; if (err_user !== exp_user) begin n_fail++; $display("FAIL rand_user: got %b want %b", err_user, exp_user); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_out_of_order();
      test_backpressure();
      test_tlast();
      test_user();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lp_down_collector.md
LP_DOWN_COLLECTOR -- requirements
Module: lp_down_collector

Interface
REQ-001 SHALL have parameter PE_NUMBER_I, default 4: number of down lanes merged, at least 2.
REQ-002 SHALL have parameter U_D_WIDTH, default 16: tdata width per lane and on the output.
REQ-003 SHALL have parameter ID_WIDTH, default 8: output tid width, at least clog2(PE_NUMBER_I).
REQ-004 SHALL have parameter DEST_WIDTH, default 8: output tdest width.
REQ-005 SHALL have parameter USER_WIDTH, default 1: tuser width per lane and on the output.
REQ-006 SHALL have parameter OUTPUT_DEST, default 0: constant driven on m_axis_tdest.
REQ-007 SHALL have ports clk (in, 1), the single clock; all logic is on the rising edge.
REQ-008 SHALL have rst (in, 1), reset, asynchronous and active-high.
REQ-009 SHALL have the lane inputs s_axis_down_tdata (in, PE_NUMBER_I*U_D_WIDTH), s_axis_down_tvalid/tready/tlast (in/out/in, PE_NUMBER_I each) and s_axis_down_tuser (in, PE_NUMBER_I*USER_WIDTH), with lane i on slice i.
REQ-010 SHALL have the merged output m_axis_tdata (out, U_D_WIDTH), m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tlast (out, 1), m_axis_tid (out, ID_WIDTH), m_axis_tdest (out, DEST_WIDTH) and m_axis_tuser (out, USER_WIDTH).
REQ-011 SHALL have err_unalligned_data (out, 1) and err_user_flag (out, 1), both sticky.

Function
REQ-012 SHALL give each lane a one-entry holding register: data, last, user and a hold_valid bit.
REQ-013 SHALL drive s_axis_down_tready[i] = !hold_valid[i] || (output handshake with ptr==i), so a lane accepts back-to-back with no bubble.
REQ-014 SHALL keep a lane pointer ptr, reset 0, that selects the holding register presented on the output.
REQ-015 SHALL drive m_axis_tvalid = hold_valid[ptr], with m_axis_tdata and m_axis_tuser taken from lane ptr.
REQ-016 SHALL drive m_axis_tid = ptr (zero-extended) and m_axis_tdest = OUTPUT_DEST.
REQ-017 SHALL have latency of exactly 1 cycle from lane acceptance to that beat being presented when ptr already points at the lane, with no combinational path from s_axis_down_tvalid to m_axis_tvalid.
REQ-018 SHALL advance ptr by 1 on each output handshake and wrap from PE_NUMBER_I-1 to 0, so lanes are emitted strictly in order 0..I-1 (one row).
REQ-019 SHALL hold ptr, and m_axis_tvalid low, while lane ptr is empty, even if other lanes hold data.
REQ-020 SHALL implement an FSM with states IDLE (ptr==0 and no row beat emitted) and ROW (at least one beat of the current row emitted); IDLE->ROW on a handshake with ptr==0; ROW->IDLE on a handshake with ptr==PE_NUMBER_I-1.
REQ-021 SHALL drive m_axis_tlast = (ptr==PE_NUMBER_I-1) && hold_last[PE_NUMBER_I-1].
REQ-022 SHALL accumulate row_or and row_and of the emitted lanes' last bits; on the row-closing handshake, if row_or != row_and, it SHALL set err_unalligned_data, and the beat is still emitted.
REQ-023 SHALL set err_user_flag on any output handshake whose tuser is non-zero.
REQ-024 SHALL keep tdata/tuser/tlast on the output stable while m_axis_tvalid && !m_axis_tready.
REQ-025 SHALL update a lane's register correctly under simultaneous drain and refill of that lane in one cycle: new data is loaded and hold_valid stays 1.

Reset
REQ-026 SHALL on rst clear all hold_valid, set ptr to 0, FSM to IDLE, row_or to 0, row_and to 1 and both error flags to 0, which forces m_axis_tvalid to 0 and every s_axis_down_tready to 1 one delta after rst rises; this also holds for a reset asserted mid-row, where the partial row is discarded.
REQ-027 SHALL leave the data fields of the holding registers unreset.

Structure
REQ-028 SHALL take the FSM state encoding and a clog2-based pointer-width constant from the shared LP package.
REQ-029 SHALL use one sub-module, lp_lane_holder (a one-entry AXI-Stream holding register), instantiated PE_NUMBER_I times.

Verification
REQ-030 SHALL cover: all 4 lanes offering 0x0011,0x0022,0x0033,0x0044 with tready=1 -> the same data out in lane order, tid 0..3, tlast low.
REQ-031 SHALL cover: lane 2 valid alone with 0xABCD -> no output; lane 0 then lane 1 arrive -> output 0x?,0x?,0xABCD in order, and s_axis_down_tready[2]=0 until drained.
REQ-032 SHALL cover: m_axis_tready=0 for 5 cycles mid-row -> output fields stable, ptr unchanged, and no input lost after release.
REQ-033 SHALL cover: row with all tlast=1 -> m_axis_tlast=1 only on tid 3, err_unalligned_data=0; row with only lane 1 tlast=1 -> err_unalligned_data=1 and staying 1.
REQ-034 SHALL cover: tuser=1 on lane 3 -> err_user_flag=1 after that beat's handshake.
REQ-035 SHALL cover: rst pulsed after 2 beats of a row -> the next output has tid 0, errors are 0 and all tready are 1.
